// File: rtl/autoconfig_pkg.sv
// Shared types and constants for the Zorro II autoconfig initiator:
// FSM state encoding, A6:A1 register addresses in the $E800xx page,
// Z2 memory space geometry and the size-code decoder.
package autoconfig_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD00,
    S_RD02,
    S_RD08,
    S_RDMFG,
    S_ALLOC,
    S_WR4A,
    S_WR48,
    S_WR4C,
    S_NEXT,
    S_DONE
  } state_t;

  // Word addresses (A6:A1) of the autoconfig registers
  localparam logic [5:0] ADDR_TYPE    = 6'h00;  // byte $00
  localparam logic [5:0] ADDR_SIZE    = 6'h01;  // byte $02
  localparam logic [5:0] ADDR_PROD    = 6'h02;  // byte $04, $06 follows
  localparam logic [5:0] ADDR_FLAGS   = 6'h04;  // byte $08
  localparam logic [5:0] ADDR_MFG     = 6'h08;  // byte $10..$16
  localparam logic [5:0] ADDR_BASE_HI = 6'h24;  // byte $48
  localparam logic [5:0] ADDR_BASE_LO = 6'h25;  // byte $4A
  localparam logic [5:0] ADDR_SHUTUP  = 6'h26;  // byte $4C

  // Z2 space starts at $200000 (A23:A16 = $20) and spans 128 x 64K
  localparam logic [7:0] Z2_BASE  = 8'h20;
  localparam logic [8:0] Z2_UNITS = 9'd128;

  // Decoded (already un-inverted) size code to 64K units; code 0 is 8MB
  function automatic logic [7:0] size_to_units(input logic [2:0] sz);
    if (sz == 3'd0) return 8'd128;
    else            return 8'd1 << (sz - 3'd1);
  endfunction

endpackage

// File: rtl/autoconfig_master_if.sv
// Nibble bus between the autoconfig initiator and the 68K bus-cycle engine.
interface autoconfig_master_if;
  logic       bus_req;
  logic       bus_rw;
  logic [5:0] bus_addr;
  logic [3:0] bus_wdata;
  logic [3:0] bus_rdata;
  logic       bus_ack;

  modport master (
    output bus_req, bus_rw, bus_addr, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_rw, bus_addr, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/autoconfig_master_alloc.sv
// ac_alloc: combinational placement of one board in Z2 space.
// Rounds the free pointer up to the board's natural alignment, tests
// whether the board still fits below the top of the space and produces
// the A23:A16 base and the advanced free pointer.
module ac_alloc
  import autoconfig_pkg::*;
(
  input  logic [7:0] i_nxt,
  input  logic [7:0] i_units,
  output logic [7:0] o_base,
  output logic [7:0] o_nxt_new,
  output logic       o_fit
);

  logic [8:0] w_mask;
  logic [8:0] w_sum;
  logic [8:0] w_al;
  logic [8:0] w_end;

  // 9-bit arithmetic so a full 8MB board past a non-zero pointer cannot wrap
  assign w_mask    = {1'b0, i_units} - 9'd1;
  assign w_sum     = {1'b0, i_nxt} + w_mask;
  assign w_al      = w_sum & ~w_mask;
  assign w_end     = w_al + {1'b0, i_units};
  assign o_fit     = (w_end <= Z2_UNITS);
  assign o_base    = Z2_BASE + w_al[7:0];
  assign o_nxt_new = w_end[7:0];

endmodule

// File: rtl/autoconfig_master.sv
// autoconfig_master: Zorro II autoconfig initiator.
// Walks the $E80000 chain one board at a time, reads type/size/flags,
// places each board at an aligned base in $200000-$9FFFFF and writes
// the base ($4A low nibble, then $48), or shuts the board up ($4C).
// Optional build macro AC_MFG_CAPTURE_EN adds product/manufacturer
// capture (state RDMFG, ports last_product / last_mfg).
module autoconfig_master
  import autoconfig_pkg::*;
#(
  parameter int MAX_BOARDS = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                 CLK,
  input  logic                 _RST,
  input  logic                 start,
  autoconfig_master_if.master  bus,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           board_count,
  output logic [3:0]           shut_count,
  output logic [7:0]           mem_top
`ifdef AC_MFG_CAPTURE_EN
  ,
  output logic [7:0]           last_product,
  output logic [15:0]          last_mfg
`endif
);

  state_t     r_state,   w_state_n;
  logic       r_req,     w_req_n;
  logic       r_rw,      w_rw_n;
  logic [5:0] r_addr,    w_addr_n;
  logic [3:0] r_wdata,   w_wdata_n;
  logic [7:0] r_tmo,     w_tmo_n;
  logic [7:0] r_units,   w_units_n;
  logic [7:0] r_nxt,     w_nxt_n;
  logic [7:0] r_base,    w_base_n;
  logic       r_noshut,  w_noshut_n;
  logic [3:0] r_bcnt,    w_bcnt_n;
  logic [3:0] r_scnt,    w_scnt_n;
  logic [7:0] r_mem_top, w_mem_top_n;
`ifdef AC_MFG_CAPTURE_EN
  logic [2:0]  r_mfg_idx, w_mfg_idx_n;
  logic [7:0]  r_product, w_product_n;
  logic [15:0] r_mfg,     w_mfg_n;
`endif

  logic       w_is_bus;
  logic       w_got;
  logic       w_tmo_hit;
  logic [4:0] w_total;
  logic [7:0] w_al_base;
  logic [7:0] w_al_nxt;
  logic       w_al_fit;

  assign w_is_bus  = (r_state inside {S_RD00, S_RD02, S_RD08, S_RDMFG,
                                      S_WR4A, S_WR48, S_WR4C});
  // An ack only counts while a request is actually outstanding
  assign w_got     = r_req & bus.bus_ack;
  assign w_tmo_hit = (r_tmo == 8'(TIMEOUT - 1));
  assign w_total   = {1'b0, r_bcnt} + {1'b0, r_scnt};

  ac_alloc u_alloc (
    .i_nxt     (r_nxt),
    .i_units   (r_units),
    .o_base    (w_al_base),
    .o_nxt_new (w_al_nxt),
    .o_fit     (w_al_fit)
  );

  // Next-state, bus handshake and bookkeeping; every register holds by default
  always_comb begin
    w_state_n   = r_state;
    w_req_n     = r_req;
    w_rw_n      = r_rw;
    w_addr_n    = r_addr;
    w_wdata_n   = r_wdata;
    w_tmo_n     = r_tmo;
    w_units_n   = r_units;
    w_nxt_n     = r_nxt;
    w_base_n    = r_base;
    w_noshut_n  = r_noshut;
    w_bcnt_n    = r_bcnt;
    w_scnt_n    = r_scnt;
    w_mem_top_n = r_mem_top;
`ifdef AC_MFG_CAPTURE_EN
    w_mfg_idx_n = r_mfg_idx;
    w_product_n = r_product;
    w_mfg_n     = r_mfg;
`endif

    // Bus states: address/direction follow the state so they are already
    // stable when bus_req rises one cycle after entry (this entry cycle is
    // also the mandatory idle gap between consecutive cycles).
    if (w_is_bus) begin
      w_rw_n    = 1'b1;
      w_wdata_n = 4'h0;
      case (r_state)
        S_RD00:  w_addr_n = ADDR_TYPE;
        S_RD02:  w_addr_n = ADDR_SIZE;
        S_RD08:  w_addr_n = ADDR_FLAGS;
`ifdef AC_MFG_CAPTURE_EN
        S_RDMFG: w_addr_n = (r_mfg_idx < 3'd2) ? (ADDR_PROD + {3'b0, r_mfg_idx})
                                                : (ADDR_MFG + {3'b0, r_mfg_idx} - 6'd2);
`endif
        S_WR4A: begin
          w_rw_n    = 1'b0;
          w_addr_n  = ADDR_BASE_LO;
          w_wdata_n = r_base[3:0];
        end
        S_WR48: begin
          w_rw_n    = 1'b0;
          w_addr_n  = ADDR_BASE_HI;
          w_wdata_n = r_base[7:4];
        end
        S_WR4C: begin
          w_rw_n    = 1'b0;
          w_addr_n  = ADDR_SHUTUP;
          w_wdata_n = 4'h0;
        end
        default: w_addr_n = r_addr;
      endcase

      if (!r_req) begin
        w_req_n = 1'b1;
        w_tmo_n = 8'd0;
      end else if (bus.bus_ack) begin
        w_req_n = 1'b0;
      end else if (w_tmo_hit) begin
        // No response: empty slot or dead board, either way the scan ends
        w_req_n   = 1'b0;
        w_state_n = S_DONE;
      end else begin
        w_tmo_n = r_tmo + 8'd1;
      end
    end

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_n   = S_RD00;
          w_bcnt_n    = 4'd0;
          w_scnt_n    = 4'd0;
          w_nxt_n     = 8'd0;
          w_mem_top_n = Z2_BASE;
          w_tmo_n     = 8'd0;
        end
      end
      S_RD00: begin
        if (w_got) w_state_n = (bus.bus_rdata[3:2] == 2'b11) ? S_RD02 : S_DONE;
      end
      S_RD02: begin
        if (w_got) begin
          w_units_n = size_to_units(~bus.bus_rdata[2:0]);
          w_state_n = S_RD08;
        end
      end
      S_RD08: begin
        if (w_got) begin
          w_noshut_n = ~bus.bus_rdata[2];
`ifdef AC_MFG_CAPTURE_EN
          w_mfg_idx_n = 3'd0;
          w_state_n   = S_RDMFG;
`else
          w_state_n   = S_ALLOC;
`endif
        end
      end
`ifdef AC_MFG_CAPTURE_EN
      S_RDMFG: begin
        if (w_got) begin
          case (r_mfg_idx)
            3'd0:    w_product_n[7:4] = ~bus.bus_rdata;
            3'd1:    w_product_n[3:0] = ~bus.bus_rdata;
            3'd2:    w_mfg_n[15:12]   = ~bus.bus_rdata;
            3'd3:    w_mfg_n[11:8]    = ~bus.bus_rdata;
            3'd4:    w_mfg_n[7:4]     = ~bus.bus_rdata;
            default: w_mfg_n[3:0]     = ~bus.bus_rdata;
          endcase
          if (r_mfg_idx == 3'd5) w_state_n = S_ALLOC;
          else                   w_mfg_idx_n = r_mfg_idx + 3'd1;
        end
      end
`endif
      S_ALLOC: begin
        if (w_al_fit) begin
          w_base_n    = w_al_base;
          w_nxt_n     = w_al_nxt;
          w_mem_top_n = Z2_BASE + w_al_nxt;
          w_state_n   = S_WR4A;
        end else if (r_noshut) begin
          // A board that refuses shut-up keeps the chain blocked
          w_state_n = S_DONE;
        end else begin
          w_state_n = S_WR4C;
        end
      end
      S_WR4A: begin
        if (w_got) w_state_n = S_WR48;
      end
      S_WR48: begin
        if (w_got) begin
          w_bcnt_n  = r_bcnt + 4'd1;
          w_state_n = S_NEXT;
        end
      end
      S_WR4C: begin
        if (w_got) begin
          w_scnt_n  = r_scnt + 4'd1;
          w_state_n = S_NEXT;
        end
      end
      S_NEXT: begin
        w_state_n = (w_total == 5'(MAX_BOARDS)) ? S_DONE : S_RD00;
      end
      S_DONE: begin
        w_state_n = S_IDLE;
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  // State register; reset forces the bus idle without waiting for a clock
  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      r_state   <= S_IDLE;
      r_req     <= 1'b0;
      r_rw      <= 1'b1;
      r_addr    <= 6'd0;
      r_wdata   <= 4'd0;
      r_tmo     <= 8'd0;
      r_units   <= 8'd0;
      r_nxt     <= 8'd0;
      r_base    <= 8'd0;
      r_noshut  <= 1'b0;
      r_bcnt    <= 4'd0;
      r_scnt    <= 4'd0;
      r_mem_top <= Z2_BASE;
`ifdef AC_MFG_CAPTURE_EN
      r_mfg_idx <= 3'd0;
      r_product <= 8'd0;
      r_mfg     <= 16'd0;
`endif
    end else begin
      r_state   <= w_state_n;
      r_req     <= w_req_n;
      r_rw      <= w_rw_n;
      r_addr    <= w_addr_n;
      r_wdata   <= w_wdata_n;
      r_tmo     <= w_tmo_n;
      r_units   <= w_units_n;
      r_nxt     <= w_nxt_n;
      r_base    <= w_base_n;
      r_noshut  <= w_noshut_n;
      r_bcnt    <= w_bcnt_n;
      r_scnt    <= w_scnt_n;
      r_mem_top <= w_mem_top_n;
`ifdef AC_MFG_CAPTURE_EN
      r_mfg_idx <= w_mfg_idx_n;
      r_product <= w_product_n;
      r_mfg     <= w_mfg_n;
`endif
    end
  end

  assign bus.bus_req   = r_req;
  assign bus.bus_rw    = r_rw;
  assign bus.bus_addr  = r_addr;
  assign bus.bus_wdata = r_wdata;
  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);
  assign board_count   = r_bcnt;
  assign shut_count    = r_scnt;
  assign mem_top       = r_mem_top;
`ifdef AC_MFG_CAPTURE_EN
  assign last_product  = r_product;
  assign last_mfg      = r_mfg;
`endif

endmodule

// File: tb/tb_autoconfig_master.sv
// Directed bench for autoconfig_master: a behavioural autoconfig chain
// answers nibble cycles, expected base/shut-up writes are queued when a
// scan is set up and checked as the DUT issues them.
module tb_autoconfig_master;

  typedef struct {
    logic [5:0] addr;
    logic [3:0] data;
  } wr_t;

  logic       CLK;
  logic       _RST;
  logic       start;
  logic       busy;
  logic       done;
  logic [3:0] board_count;
  logic [3:0] shut_count;
  logic [7:0] mem_top;
`ifdef AC_MFG_CAPTURE_EN
  logic [7:0]  last_product;
  logic [15:0] last_mfg;
`endif

  autoconfig_master_if bus_if ();

  autoconfig_master dut (
    .CLK         (CLK),
    ._RST        (_RST),
    .start       (start),
    .bus         (bus_if),
    .busy        (busy),
    .done        (done),
    .board_count (board_count),
    .shut_count  (shut_count),
    .mem_top     (mem_top)
`ifdef AC_MFG_CAPTURE_EN
    ,
    .last_product(last_product),
    .last_mfg    (last_mfg)
`endif
  );

  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  logic [3:0] b_type  [10];
  logic [3:0] b_size  [10];
  logic [3:0] b_flags [10];
  int   nboards = 0;
  int   brd_ptr = 0;
  wr_t  exp_q[$];
  wr_t  cur_exp;
  bit   hold_wr4a = 0;
  bit   seen_wr4a = 0;
  int   wait_cnt  = 0;
  int   last_cyc  = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural chain: ack after a short wait, only the head board answers
  initial begin
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 4'h0;
    forever begin
      @(negedge CLK);
      bus_if.bus_ack = 1'b0;
      if (_RST && bus_if.bus_req && brd_ptr < nboards &&
          !(hold_wr4a && !bus_if.bus_rw && bus_if.bus_addr == 6'h25)) begin
        if (wait_cnt < 2) wait_cnt++;
        else begin
          wait_cnt = 0;
          if (bus_if.bus_rw) begin
            case (bus_if.bus_addr)
              6'h00:   bus_if.bus_rdata = b_type[brd_ptr];
              6'h01:   bus_if.bus_rdata = b_size[brd_ptr];
              6'h04:   bus_if.bus_rdata = b_flags[brd_ptr];
              default: bus_if.bus_rdata = 4'hF;
            endcase
          end else begin
            if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
            else begin
              cur_exp.addr = 6'h3F;
              cur_exp.data = 4'hF;
            end
            check("bus_write", {6'b0, bus_if.bus_addr, bus_if.bus_wdata},
                  {6'b0, cur_exp.addr, cur_exp.data});
            if (bus_if.bus_addr == 6'h24 || bus_if.bus_addr == 6'h26) brd_ptr++;
          end
          bus_if.bus_ack = 1'b1;
        end
      end else begin
        if (hold_wr4a && bus_if.bus_req && !bus_if.bus_rw && bus_if.bus_addr == 6'h25)
          seen_wr4a = 1;
        wait_cnt = 0;
      end
    end
  end

  task automatic add_board(input logic [3:0] t, input logic [3:0] s, input logic [3:0] f);
    b_type[nboards]  = t;
    b_size[nboards]  = s;
    b_flags[nboards] = f;
    nboards++;
  endtask

  task automatic push_wr(input logic [5:0] a, input logic [3:0] d);
    exp_q.push_back('{addr: a, data: d});
  endtask

  task automatic run_scan(input int budget, input bit mid_start);
    int cyc;
    bit seen;
    cyc  = 0;
    seen = 0;
    brd_ptr = 0;
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    while (!seen && cyc < budget) begin
      start = (mid_start && cyc == 30);
      if (done === 1'b1) seen = 1;
      else begin
        @(negedge CLK);
        cyc++;
      end
    end
    start    = 1'b0;
    last_cyc = cyc;
    check("scan_done", {15'b0, seen}, 16'h1);
  endtask

  task automatic check_end(input string tag, input logic [3:0] bc, input logic [3:0] sc,
                           input logic [7:0] mt);
    check({tag, "_board_count"}, {12'b0, board_count}, {12'b0, bc});
    check({tag, "_shut_count"}, {12'b0, shut_count}, {12'b0, sc});
    check({tag, "_mem_top"}, {8'b0, mem_top}, {8'b0, mt});
    check({tag, "_bus_req"}, {15'b0, bus_if.bus_req}, 16'h0);
    check({tag, "_writes_left"}, 16'(exp_q.size()), 16'h0);
  endtask

  initial begin
    _RST  = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    check("rst_bus_req", {15'b0, bus_if.bus_req}, 16'h0);
    check("rst_bus_rw", {15'b0, bus_if.bus_rw}, 16'h1);
    check("rst_bus_addr", {10'b0, bus_if.bus_addr}, 16'h0);
    check("rst_bus_wdata", {12'b0, bus_if.bus_wdata}, 16'h0);
    check("rst_busy", {15'b0, busy}, 16'h0);
    check("rst_done", {15'b0, done}, 16'h0);
    check("rst_counts", {8'b0, board_count, shut_count}, 16'h0);
    check("rst_mem_top", {8'b0, mem_top}, 16'h0020);
    _RST = 1'b1;

    // One 2MB board: base $20, next free $40
    nboards = 0;
    add_board(4'hE, 4'h1, 4'hF);
    push_wr(6'h25, 4'h0);
    push_wr(6'h24, 4'h2);
    run_scan(2000, 0);
    check_end("one2m", 4'd1, 4'd0, 8'h40);
    @(negedge CLK);
    check("idle_after_done", {14'b0, busy, done}, 16'h0);

    // Three 4MB boards: third cannot be placed and is shut up
    nboards = 0;
    add_board(4'hE, 4'h0, 4'hF);
    add_board(4'hE, 4'h0, 4'hF);
    add_board(4'hE, 4'h0, 4'hF);
    push_wr(6'h25, 4'h0);
    push_wr(6'h24, 4'h2);
    push_wr(6'h25, 4'h0);
    push_wr(6'h24, 4'h6);
    push_wr(6'h26, 4'h0);
    run_scan(2000, 0);
    check_end("three4m", 4'd2, 4'd1, 8'hA0);

    // Empty chain: no ack at all, ends on timeout
    nboards = 0;
    run_scan(2000, 0);
    check_end("empty", 4'd0, 4'd0, 8'h20);
    check("empty_timeout_len", {15'b0, (last_cyc >= 250 && last_cyc <= 265)}, 16'h1);

    // 64K then 2MB: alignment gap, with a stray start mid-scan
    nboards = 0;
    add_board(4'hE, 4'h6, 4'hF);
    add_board(4'hE, 4'h1, 4'hF);
    push_wr(6'h25, 4'h0);
    push_wr(6'h24, 4'h2);
    push_wr(6'h25, 4'h0);
    push_wr(6'h24, 4'h4);
    run_scan(2000, 1);
    check_end("gap", 4'd2, 4'd0, 8'h60);

    // 64K then 8MB that refuses shut-up: chain blocked, no $4C write
    nboards = 0;
    add_board(4'hE, 4'h6, 4'hF);
    add_board(4'hE, 4'h7, 4'h0);
    push_wr(6'h25, 4'h0);
    push_wr(6'h24, 4'h2);
    run_scan(2000, 0);
    check_end("noshut", 4'd1, 4'd0, 8'h21);
    check("noshut_fast", {15'b0, (last_cyc < 100)}, 16'h1);

    // Nine 64K boards: scan stops after eight
    nboards = 0;
    for (int i = 0; i < 9; i++) add_board(4'hE, 4'h6, 4'hF);
    for (int i = 0; i < 8; i++) begin
      push_wr(6'h25, 4'(i));
      push_wr(6'h24, 4'h2);
    end
    run_scan(3000, 0);
    check_end("max", 4'd8, 4'd0, 8'h28);
    check("max_no_ninth", 16'(brd_ptr), 16'd8);

    // Reset while the $4A write is outstanding, then a clean rescan
    nboards = 0;
    add_board(4'hE, 4'h1, 4'hF);
    hold_wr4a = 1;
    seen_wr4a = 0;
    brd_ptr   = 0;
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    for (int i = 0; i < 200 && !seen_wr4a; i++) begin
      @(negedge CLK);
      #1;
    end
    check("wr4a_reached", {15'b0, seen_wr4a}, 16'h1);
    #1;
    _RST = 1'b0;
    #1;
    check("midrst_bus_req", {15'b0, bus_if.bus_req}, 16'h0);
    check("midrst_busy", {15'b0, busy}, 16'h0);
    check("midrst_mem_top", {8'b0, mem_top}, 16'h0020);
    hold_wr4a = 0;
    repeat (2) @(negedge CLK);
    _RST = 1'b1;
    push_wr(6'h25, 4'h0);
    push_wr(6'h24, 4'h2);
    run_scan(2000, 0);
    check_end("rescan", 4'd1, 4'd0, 8'h40);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
